pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
Parametrised multi-channel PWM generator with a runtime-programmable period, per-channel duty cycles, a clock prescaler, and a selectable edge-aligned or center-aligned mode. Period, duty and mode values pass through shadow registers and become active only at a period boundary, so output pulses never glitch. The block drives motor, LED and servo outputs from the rotary-encoder control path.

Parameters:
CHANNELS, 4, number of PWM outputs (1..16)
CNT_WIDTH, 8, width of the period counter, period and duty values
PRE_WIDTH, 8, width of the prescaler divide value

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  1 = run; 0 = counters held at 0 and outputs low
prescale  in  PRE_WIDTH  counter advances once every prescale+1 clk cycles
period_in  in  CNT_WIDTH  pending period value P
mode_in  in  1  pending mode: 0 = edge-aligned, 1 = center-aligned
duty_in  in  CHANNELS*CNT_WIDTH  pending duties; channel i uses bits [i*CNT_WIDTH +: CNT_WIDTH]
load  in  1  single-cycle pulse; captures period_in, mode_in and duty_in into the shadow registers
pwm  out  CHANNELS  PWM outputs
period_start  out  1  one-clk pulse in the cycle the active counter becomes 0 at a boundary
count  out  CNT_WIDTH  active counter value, for debug

Behaviour:
- Clock and reset: a single clock, clk, is used throughout. rst is synchronous and active-high.
- Reset values:
  - prescaler, count, active duties, active period, active mode, shadow registers, pending flag: all 0
  - direction: up
  - pwm: 0
  - period_start: 0
- Prescaler:
  - Counts 0..prescale.
  - tick = enable && (prescaler == prescale); prescaler wraps to 0 on tick.
  - prescale = 0 gives a tick every cycle.
  - prescale is sampled live, not shadowed.
  - If prescale is lowered below the current prescaler value, the prescaler counts up to its maximum and wraps; the next tick fires at the new value.
- Edge-aligned mode (active mode = 0):
  - On tick: count goes 0,1,…,P, then 0.
  - Period = (P+1)*(prescale+1) clk cycles.
  - Boundary = tick while count == P.
- Center-aligned mode (active mode = 1):
  - On tick: count goes 0,1,…,P, then P-1,…,1, then 0.
  - Period = 2P ticks.
  - The direction flips to down on the tick where count == P, and flips back to up on the tick where count goes 1→0.
  - Boundary = that 1→0 transition.
  - P = 0 in center mode behaves as edge mode with P = 0.
- Shadow loading:
  - load sets the shadow registers and a pending flag.
  - At a boundary with the pending flag set, the shadow values are copied to the active registers and the pending flag is cleared.
  - If load coincides with a boundary, the value presented that cycle is applied at that same boundary.
  - A second load before the boundary overwrites the first; only the last one is applied.
  - While enable = 0, a pending load is applied immediately on the next cycle.
- Output compare:
  - pwm[i] is registered: pwm[i] <= enable && (count < duty_active[i]), so pwm lags count by exactly 1 clk.
  - duty = 0 → constant low.
  - duty ≥ P+1 → constant high in edge mode.
  - In center mode, the high time is 2*duty-1 ticks, symmetric about count = 0.
- period_start: registered together with count; high for exactly 1 clk per boundary. Never asserts while enable = 0.
- enable falling: on the next clk, prescaler = 0, count = 0, direction = up, and pwm = 0.
- enable rising: counting restarts from count = 0. The first period_start fires at the first boundary, not at restart.
- Mode change:
  - Takes effect only at a boundary; the direction is reset to up at that boundary.
  - A change from center to edge mode occurs at count = 0, so there is no discontinuity.
- rst mid-period: all state returns to reset values on the next edge. Any pending load is discarded.
- Arithmetic: all comparisons are unsigned at CNT_WIDTH. count never exceeds P, and never wraps through 2^CNT_WIDTH except when P = 2^CNT_WIDTH-1.

Test Plan:
1. rst=1 for 3 cycles, then enable=1, prescale=0, P=9, mode=0, load with duty {0,3,5,10} → pwm[0] always 0, pwm[1] high 3 of 10 cycles, pwm[2] high 5 of 10, pwm[3] always 1; period_start every 10 clk.
2. prescale=3, P=4, duty=2 → period 20 clk, pwm high for 8 consecutive clk per period; count holds each value 4 clk.
3. mode=1, P=4, duty=2 → count sequence 0,1,2,3,4,3,2,1 repeating; pwm high on count ∈ {0,1} (3 ticks per 8-tick period, delayed 1 clk); period_start every 8 ticks.
4. Mid-period load of duty 7 at count=3 with P=9 → pwm keeps the old duty until the boundary; the first period at duty 7 starts 1 clk after period_start.
5. load asserted in the same cycle as a boundary, then a second load one cycle later → first value applied immediately, second at the next boundary.
6. Deassert enable at count=6, hold for 5 cycles, reassert → pwm = 0 and count = 0 during the gap; rst asserted mid-period → outputs 0 next clk and the pending load is discarded.

Source files
------------

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared prescaled counter, edge- or center-aligned modes,
// and shadowed period/duty/mode that only take effect at period boundaries.
module pwm_multi #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned PRE_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [PRE_WIDTH-1:0]          prescale,
    input  logic [CNT_WIDTH-1:0]          period_in,
    input  logic                          mode_in,
    input  logic [CHANNELS*CNT_WIDTH-1:0] duty_in,
    input  logic                          load,
    output logic [CHANNELS-1:0]           pwm,
    output logic                          period_start,
    output logic [CNT_WIDTH-1:0]          count
);
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    localparam int unsigned DW = CHANNELS * CNT_WIDTH;

    logic [PRE_WIDTH-1:0] pre_q, pre_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] period_q, period_d, sh_period_q, sh_period_d;
    logic                 dir_q, dir_d;
    logic                 mode_q, mode_d, sh_mode_q, sh_mode_d;
    logic                 pending_q, pending_d;
    logic [DW-1:0]        duty_q, duty_d, sh_duty_q, sh_duty_d;
    logic [CHANNELS-1:0]  pwm_q, pwm_d;
    logic                 pstart_q, pstart_d;

    logic                 tick, center, boundary, apply, dir_step;
    logic [CNT_WIDTH-1:0] cnt_step;

    always_comb begin
        tick   = enable && (pre_q == prescale);
        // A zero period in center mode degenerates to edge mode with P = 0.
        center = mode_q && (period_q != '0);

        if (!center) begin
            cnt_step = (cnt_q == period_q) ? '0 : cnt_q + CNT_WIDTH'(1);
            dir_step = DIR_UP;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q == period_q) begin
                cnt_step = cnt_q - CNT_WIDTH'(1);
                dir_step = DIR_DOWN;
            end else begin
                cnt_step = cnt_q + CNT_WIDTH'(1);
                dir_step = DIR_UP;
            end
        end else begin
            cnt_step = cnt_q - CNT_WIDTH'(1);
            dir_step = DIR_DOWN;
        end

        // Count only returns to 0 on a wrap (edge) or on the 1->0 step (center).
        boundary = tick && (cnt_step == '0);
        apply    = (load || pending_q) && (boundary || !enable);

        pre_d = pre_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!enable) begin
            pre_d = '0;
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (tick) begin
            pre_d = '0;
            cnt_d = cnt_step;
            dir_d = boundary ? DIR_UP : dir_step;
        end else begin
            pre_d = pre_q + PRE_WIDTH'(1);
        end

        sh_period_d = sh_period_q;
        sh_mode_d   = sh_mode_q;
        sh_duty_d   = sh_duty_q;
        pending_d   = pending_q;
        if (load) begin
            sh_period_d = period_in;
            sh_mode_d   = mode_in;
            sh_duty_d   = duty_in;
            pending_d   = 1'b1;
        end

        period_d = period_q;
        mode_d   = mode_q;
        duty_d   = duty_q;
        if (apply) begin
            period_d  = load ? period_in : sh_period_q;
            mode_d    = load ? mode_in : sh_mode_q;
            duty_d    = load ? duty_in : sh_duty_q;
            pending_d = 1'b0;
        end

        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = enable && (cnt_q < duty_q[i*CNT_WIDTH +: CNT_WIDTH]);
        end
        pstart_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q       <= '0;
            cnt_q       <= '0;
            dir_q       <= DIR_UP;
            period_q    <= '0;
            mode_q      <= 1'b0;
            duty_q      <= '0;
            sh_period_q <= '0;
            sh_mode_q   <= 1'b0;
            sh_duty_q   <= '0;
            pending_q   <= 1'b0;
            pwm_q       <= '0;
            pstart_q    <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            period_q    <= period_d;
            mode_q      <= mode_d;
            duty_q      <= duty_d;
            sh_period_q <= sh_period_d;
            sh_mode_q   <= sh_mode_d;
            sh_duty_q   <= sh_duty_d;
            pending_q   <= pending_d;
            pwm_q       <= pwm_d;
            pstart_q    <= pstart_d;
        end
    end

    assign pwm          = pwm_q;
    assign period_start = pstart_q;
    assign count        = cnt_q;
endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi: edge/center modes, prescaler, shadow loads,
// enable gaps and reset discarding a pending load.
module tb_pwm_multi;
    localparam int unsigned CHANNELS  = 4;
    localparam int unsigned CNT_WIDTH = 8;
    localparam int unsigned PRE_WIDTH = 8;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          enable;
    logic [PRE_WIDTH-1:0]          prescale;
    logic [CNT_WIDTH-1:0]          period_in;
    logic                          mode_in;
    logic [CHANNELS*CNT_WIDTH-1:0] duty_in;
    logic                          load;
    logic [CHANNELS-1:0]           pwm;
    logic                          period_start;
    logic [CNT_WIDTH-1:0]          count;

    int checks   = 0;
    int failures = 0;
    int p;
    int d;
    int cseq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

    pwm_multi #(
        .CHANNELS (CHANNELS),
        .CNT_WIDTH(CNT_WIDTH),
        .PRE_WIDTH(PRE_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .prescale    (prescale),
        .period_in   (period_in),
        .mode_in     (mode_in),
        .duty_in     (duty_in),
        .load        (load),
        .pwm         (pwm),
        .period_start(period_start),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        load      = 1'b0;
        prescale  = '0;
        period_in = '0;
        mode_in   = 1'b0;
        duty_in   = '0;
        for (int i = 0; i < 3; i++) step();
        check("rst_count", 32'(count), 32'd0);
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_pstart", 32'(period_start), 32'd0);

        // Edge mode, P=9, duties {10,5,3,0}, loaded while disabled.
        rst       = 1'b0;
        period_in = 8'd9;
        duty_in   = {8'd10, 8'd5, 8'd3, 8'd0};
        load      = 1'b1;
        step();
        load   = 1'b0;
        enable = 1'b1;
        check("t1_start_count", 32'(count), 32'd0);
        check("t1_start_pstart", 32'(period_start), 32'd0);
        for (int k = 1; k <= 30; k++) begin
            step();
            p = (k - 1) % 10;
            check("t1_count", 32'(count), 32'(k % 10));
            check("t1_pwm", 32'(pwm), 32'({1'b1, p < 5, p < 3, 1'b0}));
            check("t1_pstart", 32'(period_start), 32'((k % 10) == 0));
        end

        // Edge mode with prescale=3, P=4, duty 2.
        enable    = 1'b0;
        prescale  = 8'd3;
        period_in = 8'd4;
        duty_in   = {4{8'd2}};
        load      = 1'b1;
        step();
        check("t2_off_count", 32'(count), 32'd0);
        check("t2_off_pwm", 32'(pwm), 32'd0);
        check("t2_off_pstart", 32'(period_start), 32'd0);
        load   = 1'b0;
        enable = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            step();
            check("t2_count", 32'(count), 32'((j / 4) % 5));
            check("t2_pwm", 32'(pwm), 32'({4{(((j - 1) / 4) % 5) < 2}}));
            check("t2_pstart", 32'(period_start), 32'((j % 20) == 0));
        end

        // Center mode, P=4, duty 2, prescale 0.
        enable    = 1'b0;
        prescale  = 8'd0;
        mode_in   = 1'b1;
        period_in = 8'd4;
        duty_in   = {4{8'd2}};
        load      = 1'b1;
        step();
        check("t3_off_count", 32'(count), 32'd0);
        load   = 1'b0;
        enable = 1'b1;
        for (int m = 1; m <= 24; m++) begin
            step();
            check("t3_count", 32'(count), 32'(cseq[m % 8]));
            check("t3_pwm", 32'(pwm), 32'({4{cseq[(m - 1) % 8] < 2}}));
            check("t3_pstart", 32'(period_start), 32'((m % 8) == 0));
        end

        // Edge mode P=9 duty 4; mid-period load of 7, then load at a boundary plus one after.
        enable    = 1'b0;
        mode_in   = 1'b0;
        period_in = 8'd9;
        duty_in   = {4{8'd4}};
        load      = 1'b1;
        step();
        check("t4_off_count", 32'(count), 32'd0);
        load   = 1'b0;
        enable = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            step();
            p = (n - 1) % 10;
            d = (n <= 10) ? 4 : (n <= 30) ? 7 : (n <= 40) ? 2 : 6;
            check("t45_count", 32'(count), 32'(n % 10));
            check("t45_pwm", 32'(pwm), 32'({4{p < d}}));
            check("t45_pstart", 32'(period_start), 32'((n % 10) == 0));
            if (n == 3) begin
                load    = 1'b1;
                duty_in = {4{8'd7}};
            end else if (n == 29) begin
                load    = 1'b1;
                duty_in = {4{8'd2}};
            end else if (n == 30) begin
                load    = 1'b1;
                duty_in = {4{8'd6}};
            end else begin
                load = 1'b0;
            end
        end

        // Enable gap starting at count 6.
        for (int r = 0; r < 6; r++) step();
        check("t6_pre_count", 32'(count), 32'd6);
        enable = 1'b0;
        for (int h = 1; h <= 5; h++) begin
            step();
            check("t6_gap_count", 32'(count), 32'd0);
            check("t6_gap_pwm", 32'(pwm), 32'd0);
            check("t6_gap_pstart", 32'(period_start), 32'd0);
        end
        enable = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            step();
            check("t6_re_count", 32'(count), 32'(r));
            check("t6_re_pwm", 32'(pwm), 32'd15);
            check("t6_re_pstart", 32'(period_start), 32'd0);
        end

        // Pending load followed by reset must be discarded.
        load      = 1'b1;
        period_in = 8'd3;
        duty_in   = {4{8'd1}};
        step();
        check("t6_ld_count", 32'(count), 32'd5);
        load = 1'b0;
        rst  = 1'b1;
        step();
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_pwm", 32'(pwm), 32'd0);
        check("t6_rst_pstart", 32'(period_start), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("t6_post_count", 32'(count), 32'd0);
            check("t6_post_pwm", 32'(pwm), 32'd0);
            check("t6_post_pstart", 32'(period_start), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
